// File: rtl/sound_arbiter.sv
// rtl/sound_arbiter.sv - fixed-priority arbiter sequencing four game sounds onto one tone generator
// Optional feature macro: SOUND_PREEMPT_EN (a lower-index pending sound aborts a playing note)
module sound_arbiter #(
  parameter int unsigned NOTE_TICKS = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic       mute,
  output logic       play,
  output logic [3:0] tone,
  output logic       busy,
  output logic [1:0] active_id
);

  typedef enum logic [1:0] {S_IDLE, S_NOTE1, S_NOTE2, S_GAP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(NOTE_TICKS - 1);

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] active_id_q, active_id_d;
  logic       play_q, play_d;
  logic [3:0] tone_q, tone_d;
  logic       busy_q, busy_d;

  logic       win_vld;
  logic [1:0] win_id;
  logic       preempt;
  logic       grant;
  logic       end_note;

  // Sound table: first note of each id.
  function automatic logic [3:0] note1_code(input logic [1:0] id);
    case (id)
      2'd0:    return 4'd3;
      2'd1:    return 4'd5;
      2'd2:    return 4'd8;
      default: return 4'd10;
    endcase
  endfunction

  // Sound table: second note; id2 is single-note so its entry is never played.
  function automatic logic [3:0] note2_code(input logic [1:0] id);
    case (id)
      2'd0:    return 4'd1;
      2'd1:    return 4'd3;
      2'd2:    return 4'd0;
      default: return 4'd12;
    endcase
  endfunction

  function automatic logic has_note2(input logic [1:0] id);
    return id != 2'd2;
  endfunction

  // Priority encoder: lowest pending index wins.
  always_comb begin
    win_vld = |pending_q;
    win_id  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) win_id = 2'(i);
    end
  end

`ifdef SOUND_PREEMPT_EN
  // A more important sound cuts into a note, but never into the gap.
  assign preempt = ((state_q == S_NOTE1) || (state_q == S_NOTE2)) && win_vld && (win_id < active_id_q);
`else
  assign preempt = 1'b0;
`endif

  // Next-state, counter, pending and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_id_d = active_id_q;
    grant       = 1'b0;
    end_note    = tick && (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant       = 1'b1;
          state_d     = S_NOTE1;
          active_id_d = win_id;
          cnt_d       = 4'd0;
        end
      end
      S_NOTE1, S_NOTE2: begin
        if (preempt) begin
          grant       = 1'b1;
          state_d     = S_NOTE1;
          active_id_d = win_id;
          cnt_d       = 4'd0;
        end else if (end_note) begin
          cnt_d   = 4'd0;
          state_d = ((state_q == S_NOTE1) && has_note2(active_id_q)) ? S_NOTE2 : S_GAP;
        end else if (tick) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A request arriving in the grant cycle re-arms the bit, so the sound replays.
    pending_d = (pending_q & ~(grant ? (4'b0001 << active_id_d) : 4'b0000)) | req;

    busy_d = (state_d != S_IDLE);
    play_d = ((state_d == S_NOTE1) || (state_d == S_NOTE2)) && !mute;
    case (state_d)
      S_NOTE1: tone_d = note1_code(active_id_d);
      S_NOTE2: tone_d = note2_code(active_id_d);
      default: tone_d = 4'd0;
    endcase
  end

  // State and output registers; reset silences immediately and drops pending sounds.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      pending_q   <= 4'd0;
      cnt_q       <= 4'd0;
      active_id_q <= 2'd0;
      play_q      <= 1'b0;
      tone_q      <= 4'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      active_id_q <= active_id_d;
      play_q      <= play_d;
      tone_q      <= tone_d;
      busy_q      <= busy_d;
    end
  end

  assign play      = play_q;
  assign tone      = tone_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb/tb_sound_arbiter.sv - directed self-checking bench for sound_arbiter with NOTE_TICKS=2
module tb_sound_arbiter;

  logic       clk;
  logic       resetN;
  logic       tick;
  logic [3:0] req;
  logic       mute;
  logic       play;
  logic [3:0] tone;
  logic       busy;
  logic [1:0] active_id;

  int checks = 0;
  int errors = 0;
  int tph    = 0;

  // Compressed traces: each change of tone/active_id shifts one nibble in.
  logic [63:0] tsig;
  int          tlen;
  logic [3:0]  tlast;
  logic [63:0] asig;
  int          alen;
  logic [1:0]  alast;

  sound_arbiter #(.NOTE_TICKS(2)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .tick      (tick),
    .req       (req),
    .mute      (mute),
    .play      (play),
    .tone      (tone),
    .busy      (busy),
    .active_id (active_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic record();
    if (tlen == 0 || tone != tlast) begin
      tsig  = {tsig[59:0], tone};
      tlen++;
      tlast = tone;
    end
    if (alen == 0 || active_id != alast) begin
      asig  = {asig[59:0], 2'b00, active_id};
      alen++;
      alast = active_id;
    end
  endtask

  // One clock: outputs sampled 1 time unit after the edge, then next-cycle inputs driven.
  task automatic adv();
    @(posedge clk);
    #1;
    tph++;
    tick = (tph % 4 == 0) ? 1'b1 : 1'b0;
    req  = 4'b0000;
    record();
  endtask

  task automatic run_to(input int c);
    while (tph < c) adv();
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    mute   = 1'b0;
    req    = 4'b0000;
    tick   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  // Leaves the bench in cycle 1 with ticks due in cycles 4, 8, 12, ...
  task automatic start_test();
    do_reset();
    @(posedge clk);
    #1;
    tph  = 1;
    tick = 1'b0;
    tsig = '0; tlen = 0; asig = '0; alen = 0;
    record();
  endtask

  task automatic test_reset();
    resetN = 1'b0; mute = 1'b0; req = 4'b0000; tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({play, tone, busy, active_id} !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 00", {play, tone, busy, active_id});
    end
    resetN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({play, tone, busy, active_id} !== 8'd0) begin
      errors++; $display("FAIL reset_idle_after_release: got %h want 00", {play, tone, busy, active_id});
    end
  endtask

  task automatic test_single_note();
    start_test();
    req = 4'b0100;
    adv();
    checks++;
    if (play !== 1'b0) begin errors++; $display("FAIL single_early_play: got %b want 0", play); end
    adv();
    checks++;
    if ({play, tone, busy, active_id} !== {1'b1, 4'd8, 1'b1, 2'd2}) begin
      errors++; $display("FAIL single_start: got %h want %h", {play, tone, busy, active_id}, {1'b1, 4'd8, 1'b1, 2'd2});
    end
    run_to(8);
    checks++;
    if ({play, tone} !== {1'b1, 4'd8}) begin
      errors++; $display("FAIL single_last_note_cycle: got %h want 18", {play, tone});
    end
    adv();
    checks++;
    if ({play, tone, busy} !== {1'b0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL single_gap: got %h want 01", {play, tone, busy});
    end
    run_to(12);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy: got %b want 1", busy); end
    adv();
    checks++;
    if ({busy, active_id} !== {1'b0, 2'd2}) begin
      errors++; $display("FAIL single_end: got %h want 2", {busy, active_id});
    end
    checks++;
    if ({tlen, tsig} !== {32'd3, 64'h080}) begin
      errors++; $display("FAIL single_tone_seq: got %0d:%h want 3:080", tlen, tsig);
    end
  endtask

  task automatic test_two_requests();
    start_test();
    req = 4'b1010;
    run_to(21);
    checks++;
    if ({play, busy} !== 2'b00) begin errors++; $display("FAIL two_idle_between: got %b want 00", {play, busy}); end
    adv();
    checks++;
    if ({tone, active_id} !== {4'd10, 2'd3}) begin
      errors++; $display("FAIL two_second_start: got %h want %h", {tone, active_id}, {4'd10, 2'd3});
    end
    run_to(60);
    checks++;
    if ({tlen, tsig} !== {32'd7, 64'h0530AC0}) begin
      errors++; $display("FAIL two_tone_seq: got %0d:%h want 7:0530ac0", tlen, tsig);
    end
    checks++;
    if ({alen, asig} !== {32'd3, 64'h013}) begin
      errors++; $display("FAIL two_active_seq: got %0d:%h want 3:013", alen, asig);
    end
  endtask

  task automatic test_preempt();
    start_test();
    req = 4'b1000;
    run_to(5);
    req = 4'b0001;
    adv();
    checks++;
    if ({tone, active_id} !== {4'd10, 2'd3}) begin
      errors++; $display("FAIL preempt_before: got %h want %h", {tone, active_id}, {4'd10, 2'd3});
    end
    adv();
`ifdef SOUND_PREEMPT_EN
    checks++;
    if ({tone, active_id} !== {4'd3, 2'd0}) begin
      errors++; $display("FAIL preempt_switch: got %h want %h", {tone, active_id}, {4'd3, 2'd0});
    end
    run_to(60);
    checks++;
    if ({tlen, tsig} !== {32'd5, 64'h0A310}) begin
      errors++; $display("FAIL preempt_tone_seq: got %0d:%h want 5:0a310", tlen, tsig);
    end
`else
    checks++;
    if ({tone, active_id} !== {4'd10, 2'd3}) begin
      errors++; $display("FAIL nopreempt_hold: got %h want %h", {tone, active_id}, {4'd10, 2'd3});
    end
    run_to(60);
    checks++;
    if ({tlen, tsig} !== {32'd7, 64'h0AC0310}) begin
      errors++; $display("FAIL nopreempt_tone_seq: got %0d:%h want 7:0ac0310", tlen, tsig);
    end
`endif
    checks++;
    if ({alen, asig} !== {32'd3, 64'h030}) begin
      errors++; $display("FAIL preempt_active_seq: got %0d:%h want 3:030", alen, asig);
    end
  endtask

  task automatic test_replay_during_note();
    start_test();
    req = 4'b0100;
    run_to(5);
    req = 4'b0100;
    run_to(13);
    checks++;
    if ({play, busy} !== 2'b00) begin errors++; $display("FAIL replay_idle: got %b want 00", {play, busy}); end
    adv();
    checks++;
    if ({tone, busy} !== {4'd8, 1'b1}) begin
      errors++; $display("FAIL replay_restart: got %h want 11", {tone, busy});
    end
    run_to(60);
    checks++;
    if ({tlen, tsig, busy} !== {32'd5, 64'h08080, 1'b0}) begin
      errors++; $display("FAIL replay_seq: got %0d:%h busy %b want 5:08080 busy 0", tlen, tsig, busy);
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    req = 4'b0100;
    adv();
    req = 4'b0100;
    run_to(60);
    checks++;
    if ({tlen, tsig, busy} !== {32'd5, 64'h08080, 1'b0}) begin
      errors++; $display("FAIL b2b_seq: got %0d:%h busy %b want 5:08080 busy 0", tlen, tsig, busy);
    end
  endtask

  task automatic test_reset_mid_note();
    int bad;
    start_test();
    req = 4'b0001;
    run_to(10);
    req = 4'b0101;
    run_to(12);
    checks++;
    if ({play, tone, busy} !== {1'b1, 4'd1, 1'b1}) begin
      errors++; $display("FAIL rst_pre_note2: got %h want %h", {play, tone, busy}, {1'b1, 4'd1, 1'b1});
    end
    resetN = 1'b0;
    #1;
    checks++;
    if ({play, tone, busy} !== 6'd0) begin
      errors++; $display("FAIL rst_async_silence: got %h want 00", {play, tone, busy});
    end
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    bad = 0;
    repeat (40) begin
      adv();
      if (play || busy || tone != 4'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rst_discard_pending: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_mute();
    int played;
    start_test();
    mute = 1'b1;
    req  = 4'b0001;
    adv();
    adv();
    checks++;
    if ({play, tone, busy, active_id} !== {1'b0, 4'd3, 1'b1, 2'd0}) begin
      errors++; $display("FAIL mute_start: got %h want %h", {play, tone, busy, active_id}, {1'b0, 4'd3, 1'b1, 2'd0});
    end
    played = 0;
    repeat (37) begin
      adv();
      if (play) played++;
    end
    checks++;
    if ({played, tlen, tsig} !== {32'd0, 32'd4, 64'h0310}) begin
      errors++; $display("FAIL mute_seq: got play %0d seq %0d:%h want play 0 seq 4:0310", played, tlen, tsig);
    end
    mute = 1'b0;
  endtask

  task automatic test_mute_latency();
    start_test();
    req = 4'b0010;
    run_to(4);
    mute = 1'b1;
    checks++;
    if (play !== 1'b1) begin errors++; $display("FAIL mute_registered: got %b want 1", play); end
    adv();
    checks++;
    if ({play, tone, busy} !== {1'b0, 4'd5, 1'b1}) begin
      errors++; $display("FAIL mute_applied: got %h want %h", {play, tone, busy}, {1'b0, 4'd5, 1'b1});
    end
    mute = 1'b0;
    adv();
    checks++;
    if (play !== 1'b1) begin errors++; $display("FAIL mute_released: got %b want 1", play); end
  endtask

  initial begin
    resetN = 1'b0; tick = 1'b0; req = 4'b0000; mute = 1'b0;
    tsig = '0; tlen = 0; tlast = 4'd0; asig = '0; alen = 0; alast = 2'd0;
    test_reset();
    test_single_note();
    test_two_requests();
    test_preempt();
    test_replay_during_note();
    test_back_to_back();
    test_reset_mid_note();
    test_mute();
    test_mute_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
